// File: rtl/rf_alu_pkg.sv
// Shared constants and ALU operation encodings for the rf_alu_pipe slice.
package rf_alu_pkg;

    localparam int unsigned DEF_WIDTH = 16;
    localparam int unsigned DEF_NREG  = 16;

    typedef enum logic [2:0] {
        OP_ADD = 3'b000,
        OP_AND = 3'b001,
        OP_SUB = 3'b010,
        OP_OR  = 3'b011,
        OP_XOR = 3'b100,
        OP_SLL = 3'b101,
        OP_SRL = 3'b110,
        OP_SLT = 3'b111
    } alu_op_e;

endpackage

// File: rtl/rf_alu_regfile.sv
// NREG x WIDTH register file: two combinational read ports, one write port,
// write-first read-during-write, synchronous clear.
module rf_alu_regfile
    import rf_alu_pkg::*;
#(
    parameter int unsigned WIDTH = DEF_WIDTH,
    parameter int unsigned NREG  = DEF_NREG
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    we,
    input  logic [$clog2(NREG)-1:0] wa,
    input  logic [WIDTH-1:0]        wd,
    input  logic [$clog2(NREG)-1:0] ra1,
    input  logic [$clog2(NREG)-1:0] ra2,
    output logic [WIDTH-1:0]        rd1_c,
    output logic [WIDTH-1:0]        rd2_c
);

    logic [WIDTH-1:0] mem [NREG];

    // Storage update: reset clears every entry, otherwise single write port.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < int'(NREG); i++) begin
                mem[i] <= '0;
            end
        end else if (we) begin
            mem[wa] <= wd;
        end
    end

    // A read of the address being written this cycle returns the new data.
    assign rd1_c = (we && (wa == ra1)) ? wd : mem[ra1];
    assign rd2_c = (we && (wa == ra2)) ? wd : mem[ra2];

endmodule

// File: rtl/rf_alu_pipe.sv
// Two-stage register-file + ALU pipeline: issue/operand latch, then
// registered result with flags and a shared writeback/external write port.
module rf_alu_pipe
    import rf_alu_pkg::*;
#(
    parameter int unsigned WIDTH = DEF_WIDTH,
    parameter int unsigned NREG  = DEF_NREG
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    rw,
    input  logic [$clog2(NREG)-1:0] wa,
    input  logic [WIDTH-1:0]        rwd,
    input  logic                    invalid,
    input  logic [$clog2(NREG)-1:0] ra1,
    input  logic [$clog2(NREG)-1:0] ra2,
    input  logic                    lm,
    input  logic [WIDTH-1:0]        md,
    input  logic                    srcb,
    input  logic [WIDTH-1:0]        signe,
    input  logic [2:0]              aluop,
    input  logic                    wben,
    input  logic [$clog2(NREG)-1:0] wbdst,
    output logic [WIDTH-1:0]        aluo,
    output logic                    outvalid,
    output logic                    zero,
    output logic                    carry,
    output logic                    ovf,
    output logic                    wconf
);

    localparam int unsigned AW = $clog2(NREG);
    localparam int unsigned SW = $clog2(WIDTH);

    // Stage-1 operand/op latch
    logic             s1_valid;
    logic [WIDTH-1:0] s1_a;
    logic [WIDTH-1:0] s1_b;
    alu_op_e          s1_op;
    logic             s1_wben;
    logic [AW-1:0]    s1_dst;

    // Stage-2 writeback bookkeeping (data is aluo itself)
    logic             wb_en_q;
    logic [AW-1:0]    wb_dst_q;

    logic             wb_pending_c;
    logic             rf_we_c;
    logic [AW-1:0]    rf_wa_c;
    logic [WIDTH-1:0] rf_wd_c;
    logic [WIDTH-1:0] rd1_c;
    logic [WIDTH-1:0] rd2_c;
    logic             fwd_a_c;
    logic             fwd_b_c;
    logic [WIDTH-1:0] opa_c;
    logic [WIDTH-1:0] opb_c;

    logic [WIDTH:0]   sum_c;
    logic [WIDTH-1:0] alu_res_c;
    logic             alu_carry_c;
    logic             alu_ovf_c;

    // Write port arbitration: a pending writeback always beats an external write.
    assign wb_pending_c = outvalid & wb_en_q;
    assign rf_we_c      = wb_pending_c | rw;
    assign rf_wa_c      = wb_pending_c ? wb_dst_q : wa;
    assign rf_wd_c      = wb_pending_c ? aluo : rwd;

    rf_alu_regfile #(
        .WIDTH (WIDTH),
        .NREG  (NREG)
    ) u_regfile (
        .clk   (clk),
        .reset (reset),
        .we    (rf_we_c),
        .wa    (rf_wa_c),
        .wd    (rf_wd_c),
        .ra1   (ra1),
        .ra2   (ra2),
        .rd1_c (rd1_c),
        .rd2_c (rd2_c)
    );

    // The op now in stage 1 is younger than anything in the register file,
    // so its result is forwarded ahead of the RF read for dependent issues.
    assign fwd_a_c = s1_valid & s1_wben & (s1_dst == ra1);
    assign fwd_b_c = s1_valid & s1_wben & (s1_dst == ra2);
    assign opa_c   = lm   ? md    : (fwd_a_c ? alu_res_c : rd1_c);
    assign opb_c   = srcb ? signe : (fwd_b_c ? alu_res_c : rd2_c);

    // ALU: result, carry (ADD carry-out / SUB not-borrow) and signed overflow.
    always_comb begin
        sum_c       = '0;
        alu_res_c   = '0;
        alu_carry_c = 1'b0;
        alu_ovf_c   = 1'b0;
        case (s1_op)
            OP_ADD: begin
                sum_c       = {1'b0, s1_a} + {1'b0, s1_b};
                alu_res_c   = sum_c[WIDTH-1:0];
                alu_carry_c = sum_c[WIDTH];
                alu_ovf_c   = (s1_a[WIDTH-1] == s1_b[WIDTH-1]) &&
                              (alu_res_c[WIDTH-1] != s1_a[WIDTH-1]);
            end
            OP_SUB: begin
                sum_c       = {1'b0, s1_a} + {1'b0, ~s1_b} + (WIDTH+1)'(1);
                alu_res_c   = sum_c[WIDTH-1:0];
                alu_carry_c = sum_c[WIDTH];
                alu_ovf_c   = (s1_a[WIDTH-1] != s1_b[WIDTH-1]) &&
                              (alu_res_c[WIDTH-1] != s1_a[WIDTH-1]);
            end
            OP_AND:  alu_res_c = s1_a & s1_b;
            OP_OR:   alu_res_c = s1_a | s1_b;
            OP_XOR:  alu_res_c = s1_a ^ s1_b;
            OP_SLL:  alu_res_c = s1_a << s1_b[SW-1:0];
            OP_SRL:  alu_res_c = s1_a >> s1_b[SW-1:0];
            OP_SLT:  alu_res_c = WIDTH'($signed(s1_a) < $signed(s1_b));
            default: alu_res_c = '0;
        endcase
    end

    // Stage 1: capture operands and control on an issue strobe.
    always_ff @(posedge clk) begin
        if (reset) begin
            s1_valid <= 1'b0;
            s1_a     <= '0;
            s1_b     <= '0;
            s1_op    <= OP_ADD;
            s1_wben  <= 1'b0;
            s1_dst   <= '0;
        end else begin
            s1_valid <= invalid;
            if (invalid) begin
                s1_a    <= opa_c;
                s1_b    <= opb_c;
                s1_op   <= alu_op_e'(aluop);
                s1_wben <= wben;
                s1_dst  <= wbdst;
            end
        end
    end

    // Stage 2: register result, flags and writeback intent; flag dropped writes.
    always_ff @(posedge clk) begin
        if (reset) begin
            aluo     <= '0;
            outvalid <= 1'b0;
            zero     <= 1'b0;
            carry    <= 1'b0;
            ovf      <= 1'b0;
            wconf    <= 1'b0;
            wb_en_q  <= 1'b0;
            wb_dst_q <= '0;
        end else begin
            outvalid <= s1_valid;
            wconf    <= rw & wb_pending_c;
            if (s1_valid) begin
                aluo     <= alu_res_c;
                zero     <= (alu_res_c == '0);
                carry    <= alu_carry_c;
                ovf      <= alu_ovf_c;
                wb_en_q  <= s1_wben;
                wb_dst_q <= s1_dst;
            end
        end
    end

endmodule

// File: tb/tb_rf_alu_pipe.sv
// Self-checking bench for rf_alu_pipe (WIDTH=16, NREG=16): vector table,
// scoreboard-checked results, forwarding, write conflict and reset corners.
module tb_rf_alu_pipe;
    import rf_alu_pkg::*;

    logic        clk = 1'b0;
    logic        reset;
    logic        rw;
    logic [3:0]  wa;
    logic [15:0] rwd;
    logic        invalid;
    logic [3:0]  ra1, ra2;
    logic        lm;
    logic [15:0] md;
    logic        srcb;
    logic [15:0] signe;
    logic [2:0]  aluop;
    logic        wben;
    logic [3:0]  wbdst;
    logic [15:0] aluo;
    logic        outvalid, zero, carry, ovf, wconf;

    rf_alu_pipe #(.WIDTH(16), .NREG(16)) dut (
        .clk(clk), .reset(reset), .rw(rw), .wa(wa), .rwd(rwd),
        .invalid(invalid), .ra1(ra1), .ra2(ra2), .lm(lm), .md(md),
        .srcb(srcb), .signe(signe), .aluop(aluop), .wben(wben), .wbdst(wbdst),
        .aluo(aluo), .outvalid(outvalid), .zero(zero), .carry(carry),
        .ovf(ovf), .wconf(wconf)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_checks = 0;
    int n_fail   = 0;

    typedef struct {
        logic [15:0] res;
        logic        z, c, o;
        int          cyc;
        int          id;
    } exp_t;
    exp_t sbq[$];

    typedef struct {
        logic [2:0]  op;
        logic [15:0] a, b, res;
        logic        z, c, o;
    } vec_t;
    vec_t vt[13];

    logic [15:0] model [16];

    function automatic void check(input string name, input int id,
                                  input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s id=%0d: got %0h expected %0h", name, id, act, exp);
        end
    endfunction

    // Reference ALU built on integer arithmetic.
    task automatic alu_ref(input logic [2:0] op, input logic [15:0] a, b,
                           output logic [15:0] r, output logic z, c, o);
        int ua, ub, sa, sb, t, s;
        logic [3:0] sh;
        ua = int'(a); ub = int'(b);
        sa = int'($signed(a)); sb = int'($signed(b));
        sh = b[3:0];
        c = 1'b0; o = 1'b0;
        case (op)
            3'd0: begin t = ua + ub; r = 16'(t); c = (t > 65535);
                        s = sa + sb; o = (s > 32767) || (s < -32768); end
            3'd2: begin t = ua - ub; r = 16'(t); c = (ua >= ub);
                        s = sa - sb; o = (s > 32767) || (s < -32768); end
            3'd1: r = a & b;
            3'd3: r = a | b;
            3'd4: r = a ^ b;
            3'd5: r = a << sh;
            3'd6: r = a >> sh;
            default: r = (sa < sb) ? 16'd1 : 16'd0;
        endcase
        z = (r == 16'd0);
    endtask

    task automatic tick();
        @(posedge clk); #1;
        invalid = 1'b0; rw = 1'b0; wben = 1'b0; lm = 1'b0; srcb = 1'b0;
    endtask

    task automatic drive_iss(input logic [2:0] op, input logic [3:0] a1, a2,
                             input logic l, input logic [15:0] m,
                             input logic s, input logic [15:0] se,
                             input logic we, input logic [3:0] d);
        invalid = 1'b1; aluop = op; ra1 = a1; ra2 = a2; lm = l; md = m;
        srcb = s; signe = se; wben = we; wbdst = d;
    endtask

    task automatic push_exp(input logic [15:0] r, input logic z, c, o, input int id);
        exp_t e;
        e.res = r; e.z = z; e.c = c; e.o = o; e.cyc = cyc + 2; e.id = id;
        sbq.push_back(e);
    endtask

    // Issue an op; expectation from the sequential model (prior issues visible).
    task automatic set_iss(input logic [2:0] op, input logic [3:0] a1, a2,
                           input logic l, input logic [15:0] m,
                           input logic s, input logic [15:0] se,
                           input logic we, input logic [3:0] d,
                           input int id, input bit push);
        logic [15:0] a, b, r;
        logic z, c, o;
        a = l ? m : model[a1];
        b = s ? se : model[a2];
        alu_ref(op, a, b, r, z, c, o);
        if (we) model[d] = r;
        if (push) push_exp(r, z, c, o, id);
        drive_iss(op, a1, a2, l, m, s, se, we, d);
    endtask

    task automatic set_wr(input logic [3:0] addr, input logic [15:0] data);
        rw = 1'b1; wa = addr; rwd = data; model[addr] = data;
    endtask

    task automatic readreg(input logic [3:0] r, input int id);
        set_iss(3'd0, r, 4'd0, 1'b0, 16'd0, 1'b1, 16'd0, 1'b0, 4'd0, id, 1'b1);
    endtask

    // Output monitor: pop the scoreboard on every valid result.
    always @(negedge clk) begin
        exp_t e;
        if (outvalid) begin
            if (sbq.size() == 0) begin
                check("spurious_outvalid", -1, 64'(outvalid), 64'd0);
            end else begin
                e = sbq.pop_front();
                check("aluo",    e.id, 64'(aluo),  64'(e.res));
                check("zero",    e.id, 64'(zero),  64'(e.z));
                check("carry",   e.id, 64'(carry), 64'(e.c));
                check("ovf",     e.id, 64'(ovf),   64'(e.o));
                check("latency", e.id, 64'(cyc),   64'(e.cyc));
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog id=0: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        vt[0]  = '{3'd0, 16'h7FFF, 16'h0001, 16'h8000, 1'b0, 1'b0, 1'b1};
        vt[1]  = '{3'd0, 16'hFFFF, 16'h0001, 16'h0000, 1'b1, 1'b1, 1'b0};
        vt[2]  = '{3'd2, 16'h0004, 16'h0002, 16'h0002, 1'b0, 1'b1, 1'b0};
        vt[3]  = '{3'd2, 16'h0002, 16'h0004, 16'hFFFE, 1'b0, 1'b0, 1'b0};
        vt[4]  = '{3'd2, 16'h8000, 16'h0001, 16'h7FFF, 1'b0, 1'b1, 1'b1};
        vt[5]  = '{3'd1, 16'hF0F0, 16'h3C3C, 16'h3030, 1'b0, 1'b0, 1'b0};
        vt[6]  = '{3'd3, 16'hF0F0, 16'h0F0F, 16'hFFFF, 1'b0, 1'b0, 1'b0};
        vt[7]  = '{3'd4, 16'hAAAA, 16'hAAAA, 16'h0000, 1'b1, 1'b0, 1'b0};
        vt[8]  = '{3'd5, 16'h0001, 16'h0013, 16'h0008, 1'b0, 1'b0, 1'b0};
        vt[9]  = '{3'd6, 16'h8000, 16'h000F, 16'h0001, 1'b0, 1'b0, 1'b0};
        vt[10] = '{3'd7, 16'hFFFF, 16'h0001, 16'h0001, 1'b0, 1'b0, 1'b0};
        vt[11] = '{3'd7, 16'h0001, 16'hFFFF, 16'h0000, 1'b1, 1'b0, 1'b0};
        vt[12] = '{3'd0, 16'h0000, 16'h0000, 16'h0000, 1'b1, 1'b0, 1'b0};

        reset = 1'b1; rw = 1'b0; wa = '0; rwd = '0; invalid = 1'b0;
        ra1 = '0; ra2 = '0; lm = 1'b0; md = '0; srcb = 1'b0; signe = '0;
        aluop = '0; wben = 1'b0; wbdst = '0;
        for (int i = 0; i < 16; i++) model[i] = 16'd0;

        repeat (2) @(posedge clk);
        #1;
        check("rst_aluo",     0, 64'(aluo),     64'd0);
        check("rst_outvalid", 0, 64'(outvalid), 64'd0);
        check("rst_zero",     0, 64'(zero),     64'd0);
        check("rst_carry",    0, 64'(carry),    64'd0);
        check("rst_ovf",      0, 64'(ovf),      64'd0);
        check("rst_wconf",    0, 64'(wconf),    64'd0);
        reset = 1'b0;

        // Table vectors, issued back-to-back from the first edge after reset.
        for (int i = 0; i < 13; i++) begin
            drive_iss(vt[i].op, 4'd0, 4'd0, 1'b1, vt[i].a, 1'b1, vt[i].b, 1'b0, 4'd0);
            push_exp(vt[i].res, vt[i].z, vt[i].c, vt[i].o, 100 + i);
            tick();
        end

        // SUB from registers
        set_wr(4'd0, 16'h0004); tick();
        set_wr(4'd1, 16'h0002); tick();
        set_iss(3'd2, 4'd0, 4'd1, 1'b0, 16'd0, 1'b0, 16'd0, 1'b0, 4'd0, 200, 1'b1); tick();

        // ADD with immediate B, then register ADD
        set_wr(4'd0, 16'h0008); tick();
        set_iss(3'd0, 4'd0, 4'd0, 1'b0, 16'd0, 1'b1, 16'd0, 1'b0, 4'd0, 201, 1'b1); tick();
        set_wr(4'd0, 16'h0000); tick();
        set_wr(4'd1, 16'h0001); tick();
        set_iss(3'd0, 4'd0, 4'd1, 1'b0, 16'd0, 1'b0, 16'd0, 1'b0, 4'd0, 202, 1'b1); tick();

        // External write and issue reading it in the same cycle
        set_wr(4'd9, 16'h1111);
        set_iss(3'd0, 4'd9, 4'd9, 1'b0, 16'd0, 1'b0, 16'd0, 1'b0, 4'd0, 203, 1'b1); tick();
        check("wconf_nowb", 203, 64'(wconf), 64'd0);

        // Dependent issues with a write conflict in the writeback cycle
        set_wr(4'd5, 16'h1234); tick();
        set_wr(4'd0, 16'h0003); tick();
        set_wr(4'd1, 16'h0005); tick();
        set_iss(3'd0, 4'd0, 4'd1, 1'b0, 16'd0, 1'b0, 16'd0, 1'b1, 4'd2, 300, 1'b1); tick();
        set_iss(3'd0, 4'd2, 4'd2, 1'b0, 16'd0, 1'b0, 16'd0, 1'b1, 4'd3, 301, 1'b1); tick();
        rw = 1'b1; wa = 4'd5; rwd = 16'hBEEF; tick();
        check("wconf_pulse", 302, 64'(wconf), 64'd1);
        tick();
        check("wconf_clear", 303, 64'(wconf), 64'd0);
        readreg(4'd5, 304); tick();
        readreg(4'd2, 305); tick();
        readreg(4'd3, 306); tick();

        // Read in the same cycle as the writeback of an earlier op
        set_iss(3'd0, 4'd2, 4'd0, 1'b0, 16'd0, 1'b1, 16'd1, 1'b1, 4'd4, 310, 1'b1); tick();
        tick();
        set_iss(3'd0, 4'd4, 4'd4, 1'b0, 16'd0, 1'b0, 16'd0, 1'b0, 4'd0, 311, 1'b1); tick();

        // Back-to-back dependent chain
        set_iss(3'd0, 4'd2, 4'd0, 1'b0, 16'd0, 1'b1, 16'd1, 1'b1, 4'd10, 320, 1'b1); tick();
        set_iss(3'd0, 4'd10, 4'd10, 1'b0, 16'd0, 1'b0, 16'd0, 1'b1, 4'd10, 321, 1'b1); tick();
        set_iss(3'd2, 4'd10, 4'd2, 1'b0, 16'd0, 1'b0, 16'd0, 1'b1, 4'd11, 322, 1'b1); tick();
        readreg(4'd11, 323); tick();
        repeat (3) tick();

        // Reset with two ops in flight: neither may write back
        set_iss(3'd0, 4'd0, 4'd0, 1'b0, 16'd0, 1'b1, 16'h00AA, 1'b1, 4'd6, 400, 1'b1); tick();
        set_iss(3'd0, 4'd0, 4'd0, 1'b0, 16'd0, 1'b1, 16'h00BB, 1'b1, 4'd7, 401, 1'b0); tick();
        reset = 1'b1;
        drive_iss(3'd0, 4'd0, 4'd0, 1'b1, 16'h0055, 1'b1, 16'd0, 1'b1, 4'd8);
        rw = 1'b1; wa = 4'd12; rwd = 16'h5A5A;
        tick();
        tick();
        check("rst2_outvalid", 402, 64'(outvalid), 64'd0);
        check("rst2_aluo",     402, 64'(aluo),     64'd0);
        check("rst2_wconf",    402, 64'(wconf),    64'd0);
        reset = 1'b0;
        for (int i = 0; i < 16; i++) model[i] = 16'd0;
        for (int i = 0; i < 16; i++) begin
            readreg(4'(i), 500 + i);
            tick();
        end

        for (int k = 0; k < 20 && sbq.size() > 0; k++) tick();
        check("drain", 0, 64'(sbq.size()), 64'd0);
        repeat (2) tick();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/rf_alu_pipe.md
RF_ALU_PIPE -- requirements
Module: rf_alu_pipe

Interface
REQ-001 Parameter WIDTH, default 16: datapath width in bits; SHALL be 8..64.
REQ-002 Parameter NREG, default 16: register count; SHALL be a power of two, at least 2; AW = clog2(NREG).
REQ-003 CLK  in  1  single clock; all state SHALL change on rising edge only.
REQ-004 Reset  in  1  synchronous, active-high reset.
REQ-005 RW  in  1  external register write enable.
REQ-006 WA  in  AW  external write address; RWD  in  WIDTH  external write data.
REQ-007 InValid  in  1  issue strobe: operands and op are sampled this cycle.
REQ-008 RA1, RA2  in  AW  read addresses for operand A and operand B.
REQ-009 LM  in  1  1 = operand A from MD, 0 = from RF[RA1]; MD  in  WIDTH.
REQ-010 SrcB  in  1  1 = operand B from signE, 0 = from RF[RA2]; signE  in  WIDTH.
REQ-011 ALUOp  in  3  operation select; WbEn  in  1  write result back; WbDst  in  AW  writeback address.
REQ-012 ALUO  out  WIDTH  registered result; OutValid  out  1  ALUO valid this cycle.
REQ-013 Zero, Carry, Ovf  out  1 each  registered flags for ALUO.
REQ-014 WConf  out  1  one-cycle pulse: an external write was dropped.

Function
REQ-015 Stage 1: on an edge with InValid=1, the block SHALL latch the operand-A source, the operand-B source, ALUOp, WbEn and WbDst, and SHALL set an internal stage-1 valid.
REQ-016 Stage 2: on the following edge, the block SHALL register the ALU result and flags into ALUO, Zero, Carry and Ovf, and SHALL assert OutValid for exactly one cycle per issue.
REQ-017 Latency SHALL be 2 cycles from the issue edge; throughput SHALL be one issue per cycle with no stalls.
REQ-018 ALUOp encoding: 000 ADD, 001 AND, 010 SUB (A-B), 011 OR, 100 XOR, 101 SLL, 110 SRL, 111 SLT.
REQ-019 SLL and SRL SHALL shift A by B[clog2(WIDTH)-1:0]; SLT SHALL return 1 if A<B signed, else 0.
REQ-020 Results SHALL wrap modulo 2^WIDTH.
REQ-021 Carry SHALL be the carry-out for ADD and NOT borrow for SUB, and 0 for all other ops.
REQ-022 Ovf SHALL be the signed overflow for ADD and SUB, and 0 for all other ops.
REQ-023 Zero SHALL be 1 iff ALUO==0.
REQ-024 Writeback: in the cycle OutValid=1 with captured WbEn=1, the block SHALL write RF[WbDst] <= result at the next edge.
REQ-025 Write port arbitration: a pending writeback SHALL win; a simultaneous external RW=1 write SHALL be dropped and WConf SHALL pulse.
REQ-026 External write: RW=1 with no writeback pending SHALL write RF[WA] <= RWD at the edge.
REQ-027 Register 0 SHALL be an ordinary writable register.
REQ-028 Read-during-write: a stage-1 read of the address written in the same cycle SHALL see the new data (write-first forwarding).
REQ-029 Forwarding SHALL make back-to-back dependent issues correct without software gaps.
REQ-030 LM=1 and SrcB=1 SHALL bypass the RF read on their respective operands; both MAY be set at once.

Reset
REQ-031 Reset=1 at an edge SHALL clear all RF entries, operand latches, ALUO, flags, OutValid, WConf and the internal valids to 0.
REQ-032 Reset SHALL override InValid and RW in the same cycle.
REQ-033 Operations in flight at reset SHALL be discarded with no writeback.
REQ-034 The first issue is accepted on the first edge after Reset deasserts.

Structure
REQ-035 Package rf_alu_pkg SHALL hold the ALUOp encodings and the default WIDTH and NREG constants.
REQ-036 Sub-module rf_alu_regfile SHALL implement the NREG x WIDTH register file: 2 read ports, 1 write port, write-first; synchronous reset clear.

Verification
REQ-037 Scenario 1: write R0=0x0004, R1=0x0002; issue SUB RA1=0, RA2=1 -> after 2 cycles ALUO=0x0002, Carry=1, Zero=0.
REQ-038 Scenario 2: R0=0x0008; issue ADD with SrcB=1, signE=0 -> ALUO=0x0008; R0=0, R1=1, ADD -> ALUO=0x0001.
REQ-039 Scenario 3: LM=1, MD=0, SrcB=1, signE=0, ADD -> ALUO=0x0000, Zero=1.
REQ-040 Scenario 4: ADD 0x7FFF+0x0001 -> ALUO=0x8000, Ovf=1, Carry=0; SLT 0xFFFF vs 0x0001 -> 0x0001.
REQ-041 Scenario 5: issue ADD R2=R0+R1 with WbEn=1, then next cycle ADD R3=R2+R2 -> correct values via forwarding; a concurrent RW to R5 in the writeback cycle -> WConf=1 and R5 unchanged.
REQ-042 Scenario 6: assert Reset while 2 ops are in flight -> OutValid stays 0, no RF write occurs, and all registers read 0.
